// File: rtl/toy_bus_arb_node_itcm_ack_if.sv
`default_nettype none
// ============================================================================
// Module      : toy_bus_arb_node_itcm_ack_if
// Description : ToyBusAck valid/ready channel (ack opcode, data, sideband,
//               source id, target id). The master drives the packet and valid;
//               the slave drives ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface toy_bus_arb_node_itcm_ack_if #(
   parameter int DATA_WIDTH = 256,
   parameter int SB_WIDTH   = 10,
   parameter int ID_WIDTH   = 4
);
   logic                  vld;
   logic                  rdy;
   logic                  opcode;
   logic [DATA_WIDTH-1:0] data;
   logic [SB_WIDTH-1:0]   sideband;
   logic [ID_WIDTH-1:0]   src_id;
   logic [ID_WIDTH-1:0]   tgt_id;

   modport master (
      output vld, opcode, data, sideband, src_id, tgt_id,
      input  rdy
   );

   modport slave (
      input  vld, opcode, data, sideband, src_id, tgt_id,
      output rdy
   );
endinterface
`default_nettype wire

// File: rtl/toy_bus_arb_node_itcm_ack.sv
`default_nettype none
// ============================================================================
// Module      : toy_bus_arb_node_itcm_ack
// Description : 2:1 round-robin arbiter for ToyBusAck packets on the ITCM
//               return path. Merges two decoder outputs onto one registered
//               output stage: 1-cycle latency, full throughput, strict
//               alternation under contention.
//               Optional macro TOY_BUS_ARB_PERF_CNT_EN adds saturating
//               per-input transfer counters and a conflict-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module toy_bus_arb_node_itcm_ack #(
   parameter int DATA_WIDTH = 256,
   parameter int SB_WIDTH   = 10,
   parameter int ID_WIDTH   = 4
) (
   input  wire                              clk,
   input  wire                              rst,
   toy_bus_arb_node_itcm_ack_if.slave       in0,
   toy_bus_arb_node_itcm_ack_if.slave       in1,
   toy_bus_arb_node_itcm_ack_if.master      out
`ifdef TOY_BUS_ARB_PERF_CNT_EN
   ,
   output logic [15:0]                      perf_cnt0,
   output logic [15:0]                      perf_cnt1,
   output logic [15:0]                      perf_conflict_cnt
`endif
);

   localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

   logic                  r_out_vld;
   logic                  r_out_opcode;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic [SB_WIDTH-1:0]   r_out_sideband;
   logic [ID_WIDTH-1:0]   r_out_src_id;
   logic [ID_WIDTH-1:0]   r_out_tgt_id;
   logic                  r_prio;

   logic w_free;
   logic w_gnt0;
   logic w_gnt1;
   logic w_xfer0;
   logic w_xfer1;

   // Output stage can accept when empty or being drained this cycle.
   assign w_free  = !r_out_vld || out.rdy;

   // Grant depends only on valids and the priority pointer, never on out.rdy.
   assign w_gnt0  = in0.vld && (!in1.vld || !r_prio);
   assign w_gnt1  = in1.vld && (!in0.vld ||  r_prio);

   assign in0.rdy = w_gnt0 && w_free;
   assign in1.rdy = w_gnt1 && w_free;

   assign w_xfer0 = in0.vld && in0.rdy;
   assign w_xfer1 = in1.vld && in1.rdy;

   assign out.vld      = r_out_vld;
   assign out.opcode   = r_out_opcode;
   assign out.data     = r_out_data;
   assign out.sideband = r_out_sideband;
   assign out.src_id   = r_out_src_id;
   assign out.tgt_id   = r_out_tgt_id;

   // Output register: load on transfer, clear valid on drain, hold on stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_vld      <= 1'b0;
         r_out_opcode   <= 1'b0;
         r_out_data     <= '0;
         r_out_sideband <= '0;
         r_out_src_id   <= '0;
         r_out_tgt_id   <= '0;
         r_prio         <= 1'b0;
      end else if (w_xfer0) begin
         r_out_vld      <= 1'b1;
         r_out_opcode   <= in0.opcode;
         r_out_data     <= in0.data;
         r_out_sideband <= in0.sideband;
         r_out_src_id   <= in0.src_id;
         r_out_tgt_id   <= in0.tgt_id;
         r_prio         <= 1'b1;
      end else if (w_xfer1) begin
         r_out_vld      <= 1'b1;
         r_out_opcode   <= in1.opcode;
         r_out_data     <= in1.data;
         r_out_sideband <= in1.sideband;
         r_out_src_id   <= in1.src_id;
         r_out_tgt_id   <= in1.tgt_id;
         r_prio         <= 1'b0;
      end else if (out.rdy) begin
         r_out_vld      <= 1'b0;
      end
   end

`ifdef TOY_BUS_ARB_PERF_CNT_EN
   logic [15:0] r_perf_cnt0;
   logic [15:0] r_perf_cnt1;
   logic [15:0] r_perf_conflict_cnt;
   logic        w_conflict;

   assign w_conflict        = in0.vld && in1.vld && w_free;
   assign perf_cnt0         = r_perf_cnt0;
   assign perf_cnt1         = r_perf_cnt1;
   assign perf_conflict_cnt = r_perf_conflict_cnt;

   // Saturating event counters for accepted transfers and conflict cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_cnt0         <= '0;
         r_perf_cnt1         <= '0;
         r_perf_conflict_cnt <= '0;
      end else begin
         if (w_xfer0 && (r_perf_cnt0 != C_CNT_MAX))
            r_perf_cnt0 <= r_perf_cnt0 + 16'd1;
         if (w_xfer1 && (r_perf_cnt1 != C_CNT_MAX))
            r_perf_cnt1 <= r_perf_cnt1 + 16'd1;
         if (w_conflict && (r_perf_conflict_cnt != C_CNT_MAX))
            r_perf_conflict_cnt <= r_perf_conflict_cnt + 16'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_toy_bus_arb_node_itcm_ack.sv
`default_nettype none
// ============================================================================
// Module      : tb_toy_bus_arb_node_itcm_ack
// Description : Directed self-checking bench for toy_bus_arb_node_itcm_ack.
//               Inputs change on the falling edge, registered outputs are
//               sampled 1 ns after the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_toy_bus_arb_node_itcm_ack;

   localparam int DW = 256;
   localparam int SW = 10;
   localparam int IW = 4;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   toy_bus_arb_node_itcm_ack_if #(.DATA_WIDTH(DW), .SB_WIDTH(SW), .ID_WIDTH(IW)) in0_if ();
   toy_bus_arb_node_itcm_ack_if #(.DATA_WIDTH(DW), .SB_WIDTH(SW), .ID_WIDTH(IW)) in1_if ();
   toy_bus_arb_node_itcm_ack_if #(.DATA_WIDTH(DW), .SB_WIDTH(SW), .ID_WIDTH(IW)) out_if ();

`ifdef TOY_BUS_ARB_PERF_CNT_EN
   logic [15:0] perf_cnt0;
   logic [15:0] perf_cnt1;
   logic [15:0] perf_conflict_cnt;
`endif

   toy_bus_arb_node_itcm_ack #(.DATA_WIDTH(DW), .SB_WIDTH(SW), .ID_WIDTH(IW)) dut (
      .clk               (clk),
      .rst               (rst),
      .in0               (in0_if),
      .in1               (in1_if),
      .out               (out_if)
`ifdef TOY_BUS_ARB_PERF_CNT_EN
      ,
      .perf_cnt0         (perf_cnt0),
      .perf_cnt1         (perf_cnt1),
      .perf_conflict_cnt (perf_conflict_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      in0_if.vld = 1'b0;
      in1_if.vld = 1'b0;
      out_if.rdy = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      in0_if.opcode = 1'b0; in0_if.data = '0; in0_if.sideband = '0;
      in0_if.src_id = 4'h1; in0_if.tgt_id = 4'h0;
      in1_if.opcode = 1'b0; in1_if.data = '0; in1_if.sideband = '0;
      in1_if.src_id = 4'h2; in1_if.tgt_id = 4'h0;
      do_reset();
      #1;
      checks++;
      if (out_if.vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", out_if.vld); end
      checks++;
      if (out_if.data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", out_if.data); end
      checks++;
      if (out_if.src_id !== 4'h0 || out_if.opcode !== 1'b0) begin
         errors++; $display("FAIL reset_fields: src %h op %b want 0 0", out_if.src_id, out_if.opcode);
      end
      // Both valid right after reset: prio=0 selects in0.
      in0_if.vld = 1'b1; in1_if.vld = 1'b1;
      #1;
      checks++;
      if (in0_if.rdy !== 1'b1 || in1_if.rdy !== 1'b0) begin
         errors++; $display("FAIL reset_prio: rdy0 %b rdy1 %b want 1 0", in0_if.rdy, in1_if.rdy);
      end
      in0_if.vld = 1'b0; in1_if.vld = 1'b0;
   endtask

   task automatic test_in0_only();
      @(negedge clk);
      out_if.rdy = 1'b1;
      in0_if.vld = 1'b1; in0_if.data = 256'hA5; in0_if.src_id = 4'h3;
      in0_if.opcode = 1'b1; in0_if.tgt_id = 4'h5; in0_if.sideband = 10'h2A7;
      #1;
      checks++;
      if (in0_if.rdy !== 1'b1 || in1_if.rdy !== 1'b0) begin
         errors++; $display("FAIL in0_only_rdy: rdy0 %b rdy1 %b want 1 0", in0_if.rdy, in1_if.rdy);
      end
      tick();
      checks++;
      if (out_if.vld !== 1'b1 || out_if.data !== 256'hA5 || out_if.src_id !== 4'h3) begin
         errors++; $display("FAIL in0_only_out: vld %b data %h src %h want 1 a5 3",
                            out_if.vld, out_if.data, out_if.src_id);
      end
      checks++;
      if (out_if.opcode !== 1'b1 || out_if.tgt_id !== 4'h5 || out_if.sideband !== 10'h2A7) begin
         errors++; $display("FAIL in0_only_fields: op %b tgt %h sb %h want 1 5 2a7",
                            out_if.opcode, out_if.tgt_id, out_if.sideband);
      end
      // prio flipped to 1 even without contention.
      @(negedge clk);
      in0_if.vld = 1'b1; in1_if.vld = 1'b1;
      #1;
      checks++;
      if (in0_if.rdy !== 1'b0 || in1_if.rdy !== 1'b1) begin
         errors++; $display("FAIL prio_flip: rdy0 %b rdy1 %b want 0 1", in0_if.rdy, in1_if.rdy);
      end
      in0_if.vld = 1'b0; in1_if.vld = 1'b0;
      tick();
      checks++;
      if (out_if.vld !== 1'b0) begin errors++; $display("FAIL in0_only_drain: vld %b want 0", out_if.vld); end
   endtask

   task automatic test_contention();
      logic [DW-1:0] exp_data;
      logic [IW-1:0] exp_src;
      int n0, n1;
      bit pick0;
      do_reset();
      n0 = 0; n1 = 0;
      in0_if.src_id = 4'h1; in1_if.src_id = 4'h2;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         out_if.rdy  = 1'b1;
         in0_if.vld  = 1'b1; in0_if.data = DW'(32'h10 + n0);
         in1_if.vld  = 1'b1; in1_if.data = DW'(32'h20 + n1);
         #1;
         pick0 = ((k % 2) == 0);
         checks++;
         if (in0_if.rdy !== pick0 || in1_if.rdy !== !pick0) begin
            errors++; $display("FAIL contention_rdy[%0d]: rdy0 %b rdy1 %b want %b %b",
                               k, in0_if.rdy, in1_if.rdy, pick0, !pick0);
         end
         exp_data = pick0 ? DW'(32'h10 + n0) : DW'(32'h20 + n1);
         exp_src  = pick0 ? 4'h1 : 4'h2;
         tick();
         checks++;
         if (out_if.vld !== 1'b1 || out_if.data !== exp_data || out_if.src_id !== exp_src) begin
            errors++; $display("FAIL contention_out[%0d]: vld %b data %h src %h want 1 %h %h",
                               k, out_if.vld, out_if.data, out_if.src_id, exp_data, exp_src);
         end
         if (pick0) n0++; else n1++;
      end
      @(negedge clk);
      in0_if.vld = 1'b0; in1_if.vld = 1'b0;
   endtask

   task automatic test_stall_and_drain();
      do_reset();
      @(negedge clk);
      out_if.rdy = 1'b1;
      in0_if.vld = 1'b1; in0_if.data = 256'h55; in0_if.src_id = 4'h1;
      tick();
      @(negedge clk);
      in0_if.vld = 1'b0;
      out_if.rdy = 1'b0;
      in1_if.vld = 1'b1; in1_if.data = 256'h66; in1_if.src_id = 4'h2;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (in1_if.rdy !== 1'b0 || in0_if.rdy !== 1'b0) begin
            errors++; $display("FAIL stall_rdy[%0d]: rdy0 %b rdy1 %b want 0 0", k, in0_if.rdy, in1_if.rdy);
         end
         tick();
         checks++;
         if (out_if.vld !== 1'b1 || out_if.data !== 256'h55 || out_if.src_id !== 4'h1) begin
            errors++; $display("FAIL stall_hold[%0d]: vld %b data %h src %h want 1 55 1",
                               k, out_if.vld, out_if.data, out_if.src_id);
         end
         @(negedge clk);
      end
      out_if.rdy = 1'b1;
      #1;
      checks++;
      if (in1_if.rdy !== 1'b1) begin errors++; $display("FAIL stall_release_rdy: rdy1 %b want 1", in1_if.rdy); end
      tick();
      checks++;
      if (out_if.vld !== 1'b1 || out_if.data !== 256'h66 || out_if.src_id !== 4'h2) begin
         errors++; $display("FAIL stall_release_out: vld %b data %h src %h want 1 66 2",
                            out_if.vld, out_if.data, out_if.src_id);
      end
      // Drain: no more valid input, output empties after one cycle, payload held.
      @(negedge clk);
      in1_if.vld = 1'b0;
      tick();
      checks++;
      if (out_if.vld !== 1'b0 || out_if.data !== 256'h66) begin
         errors++; $display("FAIL drain: vld %b data %h want 0 66", out_if.vld, out_if.data);
      end
      tick();
      checks++;
      if (out_if.vld !== 1'b0) begin errors++; $display("FAIL drain_stays: vld %b want 0", out_if.vld); end
   endtask

   task automatic test_async_reset();
      do_reset();
      @(negedge clk);
      out_if.rdy = 1'b1;
      in0_if.vld = 1'b1; in0_if.data = 256'h77; in0_if.src_id = 4'h1;
      tick();
      @(negedge clk);
      in0_if.vld = 1'b0;
      out_if.rdy = 1'b0;
      tick();
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (out_if.vld !== 1'b0 || out_if.data !== '0) begin
         errors++; $display("FAIL async_reset: vld %b data %h want 0 0", out_if.vld, out_if.data);
      end
      @(negedge clk);
      rst = 1'b0;
      out_if.rdy = 1'b1;
      in0_if.vld = 1'b1; in1_if.vld = 1'b1;
      #1;
      checks++;
      if (in0_if.rdy !== 1'b1 || in1_if.rdy !== 1'b0) begin
         errors++; $display("FAIL async_reset_prio: rdy0 %b rdy1 %b want 1 0", in0_if.rdy, in1_if.rdy);
      end
      in0_if.vld = 1'b0;
      in1_if.data = 256'h88; in1_if.src_id = 4'h2;
      #1;
      checks++;
      if (in1_if.rdy !== 1'b1) begin errors++; $display("FAIL async_reset_in1_rdy: rdy1 %b want 1", in1_if.rdy); end
      tick();
      checks++;
      if (out_if.vld !== 1'b1 || out_if.data !== 256'h88) begin
         errors++; $display("FAIL async_reset_in1_out: vld %b data %h want 1 88", out_if.vld, out_if.data);
      end
      @(negedge clk);
      in1_if.vld = 1'b0;
      tick();
   endtask

`ifdef TOY_BUS_ARB_PERF_CNT_EN
   task automatic test_perf();
      do_reset();
      @(negedge clk);
      out_if.rdy = 1'b1;
      // Two conflict cycles: in0 then in1 accepted.
      in0_if.vld = 1'b1; in1_if.vld = 1'b1;
      tick();
      @(negedge clk);
      tick();
      @(negedge clk);
      in1_if.vld = 1'b0;
      repeat (4) tick();
      @(negedge clk);
      in0_if.vld = 1'b0; in1_if.vld = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      in1_if.vld = 1'b0;
      #1;
      checks++;
      if (perf_cnt0 !== 16'd5) begin errors++; $display("FAIL perf_cnt0: got %0d want 5", perf_cnt0); end
      checks++;
      if (perf_cnt1 !== 16'd3) begin errors++; $display("FAIL perf_cnt1: got %0d want 3", perf_cnt1); end
      checks++;
      if (perf_conflict_cnt !== 16'd2) begin
         errors++; $display("FAIL perf_conflict: got %0d want 2", perf_conflict_cnt);
      end
      force dut.r_perf_cnt0 = 16'hFFFF;
      #1;
      release dut.r_perf_cnt0;
      in0_if.vld = 1'b1;
      tick();
      @(negedge clk);
      in0_if.vld = 1'b0;
      #1;
      checks++;
      if (perf_cnt0 !== 16'hFFFF) begin errors++; $display("FAIL perf_saturate: got %h want ffff", perf_cnt0); end
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      test_reset();
      test_in0_only();
      test_contention();
      test_stall_and_drain();
      test_async_reset();
`ifdef TOY_BUS_ARB_PERF_CNT_EN
      test_perf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
